// File: rtl/ocl_portal_pkg.sv
// Shared types and constants for the OCL-to-portal MMIO bridge.
package ocl_portal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_t;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ocl_portal_bridge.sv
// AXI-Lite OCL slave that serialises reads/writes into one portal request stream.
// Optional read-response timeout enabled by defining OCL_TIMEOUT_EN.
module ocl_portal_bridge
  import ocl_portal_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_main_a0,
  input  logic              rst_main,
  input  logic              sh_ocl_awvalid,
  input  logic [31:0]       sh_ocl_awaddr,
  output logic              ocl_sh_awready,
  input  logic              sh_ocl_wvalid,
  input  logic [31:0]       sh_ocl_wdata,
  input  logic [3:0]        sh_ocl_wstrb,
  output logic              ocl_sh_wready,
  output logic              ocl_sh_bvalid,
  output logic [1:0]        ocl_sh_bresp,
  input  logic              sh_ocl_bready,
  input  logic              sh_ocl_arvalid,
  input  logic [31:0]       sh_ocl_araddr,
  output logic              ocl_sh_arready,
  output logic              ocl_sh_rvalid,
  output logic [31:0]       ocl_sh_rdata,
  output logic [1:0]        ocl_sh_rresp,
  input  logic              sh_ocl_rready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
`ifdef OCL_TIMEOUT_EN
  output logic              timeout_seen,
`endif
  output logic              rsp_ready
);

  state_t state_reg, state_next;

  logic              aw_held_reg, aw_held_next;
  logic              w_held_reg, w_held_next;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic [31:0]       w_data_reg;
  logic [3:0]        w_strb_reg;
  logic              rr_last_write_reg, rr_last_write_next;

  logic              awready_reg, wready_reg, arready_reg;
  logic              bvalid_reg, rvalid_reg, rsp_ready_reg;
  logic [31:0]       rdata_reg;
  logic [1:0]        rresp_reg;
  logic              req_valid_reg, req_write_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [31:0]       req_wdata_reg;
  logic [3:0]        req_wstrb_reg;

  logic aw_capture, w_capture, read_take, wr_take, rsp_take, timeout_hit;

`ifdef OCL_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] timer_reg;
  logic        timeout_seen_reg;
  assign timeout_hit  = (state_reg == ST_RD_WAIT) && !rsp_valid && (timer_reg == TIMEOUT_LAST);
  assign timeout_seen = timeout_seen_reg;
  logic unused_bits;
  assign unused_bits = ^{sh_ocl_awaddr[31:ADDR_W], sh_ocl_araddr[31:ADDR_W]};
`else
  assign timeout_hit = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{sh_ocl_awaddr[31:ADDR_W], sh_ocl_araddr[31:ADDR_W],
                         32'(TIMEOUT_CYCLES), RESP_SLVERR, TIMEOUT_RDATA};
`endif

  // arready is precomputed so it is only high in IDLE when a read would win arbitration.
  assign aw_capture = sh_ocl_awvalid && awready_reg;
  assign w_capture  = sh_ocl_wvalid && wready_reg;
  assign read_take  = (state_reg == ST_IDLE) && sh_ocl_arvalid && arready_reg;
  assign wr_take    = (state_reg == ST_IDLE) && aw_held_reg && w_held_reg && !read_take;
  assign rsp_take   = (state_reg == ST_RD_WAIT) && rsp_valid && rsp_ready_reg;

  always_comb begin
    aw_held_next       = aw_held_reg;
    w_held_next        = w_held_reg;
    state_next         = state_reg;
    rr_last_write_next = rr_last_write_reg;

    if (wr_take) begin
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
    end
    if (aw_capture) aw_held_next = 1'b1;
    if (w_capture)  w_held_next  = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (read_take) begin
          state_next         = ST_RD_REQ;
          rr_last_write_next = 1'b0;
        end else if (wr_take) begin
          state_next         = ST_WR_REQ;
          rr_last_write_next = 1'b1;
        end
      end
      ST_WR_REQ:  if (req_ready)                state_next = ST_WR_RESP;
      ST_WR_RESP: if (sh_ocl_bready)            state_next = ST_IDLE;
      ST_RD_REQ:  if (req_ready)                state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (rsp_take || timeout_hit)  state_next = ST_RD_RESP;
      ST_RD_RESP: if (sh_ocl_rready)            state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      state_reg         <= ST_IDLE;
      aw_held_reg       <= 1'b0;
      w_held_reg        <= 1'b0;
      aw_addr_reg       <= '0;
      w_data_reg        <= '0;
      w_strb_reg        <= '0;
      rr_last_write_reg <= 1'b0;
      awready_reg       <= 1'b0;
      wready_reg        <= 1'b0;
      arready_reg       <= 1'b0;
      bvalid_reg        <= 1'b0;
      rvalid_reg        <= 1'b0;
      rsp_ready_reg     <= 1'b0;
      rdata_reg         <= '0;
      rresp_reg         <= RESP_OKAY;
      req_valid_reg     <= 1'b0;
      req_write_reg     <= 1'b0;
      req_addr_reg      <= '0;
      req_wdata_reg     <= '0;
      req_wstrb_reg     <= '0;
`ifdef OCL_TIMEOUT_EN
      timer_reg         <= '0;
      timeout_seen_reg  <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      aw_held_reg       <= aw_held_next;
      w_held_reg        <= w_held_next;
      rr_last_write_reg <= rr_last_write_next;

      if (aw_capture) aw_addr_reg <= sh_ocl_awaddr[ADDR_W-1:0];
      if (w_capture) begin
        w_data_reg <= sh_ocl_wdata;
        w_strb_reg <= sh_ocl_wstrb;
      end

      awready_reg   <= !aw_held_next;
      wready_reg    <= !w_held_next;
      arready_reg   <= (state_next == ST_IDLE) &&
                       (!(aw_held_next && w_held_next) || rr_last_write_next);
      req_valid_reg <= (state_next == ST_WR_REQ) || (state_next == ST_RD_REQ);
      rsp_ready_reg <= (state_next == ST_RD_WAIT);
      bvalid_reg    <= (state_next == ST_WR_RESP);
      rvalid_reg    <= (state_next == ST_RD_RESP);

      // Request fields load only on the IDLE decision, so they stay put while stalled.
      if (wr_take) begin
        req_write_reg <= 1'b1;
        req_addr_reg  <= aw_addr_reg;
        req_wdata_reg <= w_data_reg;
        req_wstrb_reg <= w_strb_reg;
      end else if (read_take) begin
        req_write_reg <= 1'b0;
        req_addr_reg  <= sh_ocl_araddr[ADDR_W-1:0];
        req_wdata_reg <= '0;
        req_wstrb_reg <= '0;
      end

      if (rsp_take) begin
        rdata_reg <= rsp_data;
        rresp_reg <= RESP_OKAY;
      end
`ifdef OCL_TIMEOUT_EN
      else if (timeout_hit) begin
        rdata_reg        <= TIMEOUT_RDATA;
        rresp_reg        <= RESP_SLVERR;
        timeout_seen_reg <= 1'b1;
      end
      timer_reg <= ((state_reg == ST_RD_WAIT) && (state_next == ST_RD_WAIT)) ?
                   timer_reg + 32'd1 : 32'd0;
`endif
    end
  end

  assign ocl_sh_awready = awready_reg;
  assign ocl_sh_wready  = wready_reg;
  assign ocl_sh_arready = arready_reg;
  assign ocl_sh_bvalid  = bvalid_reg;
  assign ocl_sh_bresp   = RESP_OKAY;
  assign ocl_sh_rvalid  = rvalid_reg;
  assign ocl_sh_rdata   = rdata_reg;
  assign ocl_sh_rresp   = rresp_reg;
  assign req_valid      = req_valid_reg;
  assign req_write      = req_write_reg;
  assign req_addr       = req_addr_reg;
  assign req_wdata      = req_wdata_reg;
  assign req_wstrb      = req_wstrb_reg;
  assign rsp_ready      = rsp_ready_reg;

endmodule

// File: tb/tb_ocl_portal_bridge.sv
// Self-checking bench for ocl_portal_bridge: vector table, scoreboarded portal model, corner sequences.
module tb_ocl_portal_bridge;

  localparam int BUDGET = 300;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main;
  logic        sh_ocl_awvalid, sh_ocl_wvalid, sh_ocl_bready, sh_ocl_arvalid, sh_ocl_rready;
  logic [31:0] sh_ocl_awaddr, sh_ocl_wdata, sh_ocl_araddr;
  logic [3:0]  sh_ocl_wstrb;
  logic        ocl_sh_awready, ocl_sh_wready, ocl_sh_bvalid, ocl_sh_arready, ocl_sh_rvalid;
  logic [1:0]  ocl_sh_bresp, ocl_sh_rresp;
  logic [31:0] ocl_sh_rdata;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
`ifdef OCL_TIMEOUT_EN
  logic        timeout_seen;
`endif

  ocl_portal_bridge #(.ADDR_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk_main_a0(clk_main_a0), .rst_main(rst_main),
    .sh_ocl_awvalid(sh_ocl_awvalid), .sh_ocl_awaddr(sh_ocl_awaddr), .ocl_sh_awready(ocl_sh_awready),
    .sh_ocl_wvalid(sh_ocl_wvalid), .sh_ocl_wdata(sh_ocl_wdata), .sh_ocl_wstrb(sh_ocl_wstrb),
    .ocl_sh_wready(ocl_sh_wready), .ocl_sh_bvalid(ocl_sh_bvalid), .ocl_sh_bresp(ocl_sh_bresp),
    .sh_ocl_bready(sh_ocl_bready), .sh_ocl_arvalid(sh_ocl_arvalid), .sh_ocl_araddr(sh_ocl_araddr),
    .ocl_sh_arready(ocl_sh_arready), .ocl_sh_rvalid(ocl_sh_rvalid), .ocl_sh_rdata(ocl_sh_rdata),
    .ocl_sh_rresp(ocl_sh_rresp), .sh_ocl_rready(sh_ocl_rready),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef OCL_TIMEOUT_EN
    .timeout_seen(timeout_seen),
`endif
    .rsp_ready(rsp_ready)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  int cyc = 0;
  always @(posedge clk_main_a0) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int req_count = 0;
  bit stray_req = 1'b0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          rsp_dly;
    bit          no_rsp;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          rsp_dly;
    logic [15:0] exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no handshake within %0d cycles", name, BUDGET);
  endtask

  function automatic exp_t mk_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e = '{wr: 1'b1, addr: a, wdata: d, wstrb: s, rdata: 32'h0, rsp_dly: 0, no_rsp: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk_rd(input logic [15:0] a, input logic [31:0] rd, input int dly,
                                 input bit nr);
    exp_t e;
    e = '{wr: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0, rdata: rd, rsp_dly: dly, no_rsp: nr};
    return e;
  endfunction

  // Portal model: pops the scoreboard on each request handshake and answers reads.
  initial begin
    exp_t e;
    int   k;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(negedge clk_main_a0);
      #1;
      if (stray_req) begin
        rsp_valid = 1'b1;
        rsp_data  = 32'h5555_AAAA;
        @(negedge clk_main_a0);
        rsp_valid = 1'b0;
        stray_req = 1'b0;
      end else if (req_valid && req_ready) begin
        req_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got write=%0b addr=%h, want no request", req_write, req_addr);
        end else begin
          e = exp_q.pop_front();
          chk("req_write", {31'h0, req_write}, {31'h0, e.wr});
          chk("req_addr", {16'h0, req_addr}, {16'h0, e.addr});
          chk("req_wdata", req_wdata, e.wdata);
          chk("req_wstrb", {28'h0, req_wstrb}, {28'h0, e.wstrb});
          if (!e.wr && !e.no_rsp) begin
            repeat (e.rsp_dly) @(negedge clk_main_a0);
            rsp_valid = 1'b1;
            rsp_data  = e.rdata;
            k = 0;
            while (!rsp_ready && k < BUDGET) begin
              @(negedge clk_main_a0);
              k++;
            end
            @(negedge clk_main_a0);
            rsp_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input int dly, output int hs);
    int k = 0;
    repeat (dly) @(negedge clk_main_a0);
    sh_ocl_awvalid = 1'b1;
    sh_ocl_awaddr  = a;
    while (!ocl_sh_awready && k < BUDGET) begin
      @(negedge clk_main_a0);
      k++;
    end
    if (k >= BUDGET) bound_fail("awready");
    hs = cyc + 1;
    @(negedge clk_main_a0);
    sh_ocl_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
    int k = 0;
    repeat (dly) @(negedge clk_main_a0);
    sh_ocl_wvalid = 1'b1;
    sh_ocl_wdata  = d;
    sh_ocl_wstrb  = s;
    while (!ocl_sh_wready && k < BUDGET) begin
      @(negedge clk_main_a0);
      k++;
    end
    if (k >= BUDGET) bound_fail("wready");
    hs = cyc + 1;
    @(negedge clk_main_a0);
    sh_ocl_wvalid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output int hs);
    int h1, h2;
    fork
      send_aw(a, aw_dly, h1);
      send_w(d, s, w_dly, h2);
    join
    hs = (h1 > h2) ? h1 : h2;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int k = 0;
    sh_ocl_arvalid = 1'b1;
    sh_ocl_araddr  = a;
    while (!ocl_sh_arready && k < BUDGET) begin
      @(negedge clk_main_a0);
      k++;
    end
    if (k >= BUDGET) bound_fail("arready");
    @(negedge clk_main_a0);
    sh_ocl_arvalid = 1'b0;
  endtask

  // exp_at < 0 skips the latency comparison.
  task automatic take_b(input int dly, input int exp_at);
    int k = 0;
    int bad = 0;
    while (!ocl_sh_bvalid && k < BUDGET) begin
      @(negedge clk_main_a0);
      k++;
    end
    if (k >= BUDGET) begin
      bound_fail("bvalid");
      return;
    end
    if (exp_at >= 0) chk("bvalid_cycle", cyc, exp_at);
    chk("bresp", {30'h0, ocl_sh_bresp}, 32'h0);
    repeat (dly) begin
      @(negedge clk_main_a0);
      if (!ocl_sh_bvalid) bad++;
    end
    chk("bvalid_hold_drops", bad, 0);
    sh_ocl_bready = 1'b1;
    @(negedge clk_main_a0);
    sh_ocl_bready = 1'b0;
    chk("bvalid_after_bready", {31'h0, ocl_sh_bvalid}, 32'h0);
  endtask

  task automatic take_r(input logic [31:0] data, input logic [1:0] resp, input int dly);
    int k = 0;
    int bad = 0;
    while (!ocl_sh_rvalid && k < BUDGET) begin
      @(negedge clk_main_a0);
      k++;
    end
    if (k >= BUDGET) begin
      bound_fail("rvalid");
      return;
    end
    chk("rdata", ocl_sh_rdata, data);
    chk("rresp", {30'h0, ocl_sh_rresp}, {30'h0, resp});
    repeat (dly) begin
      @(negedge clk_main_a0);
      if (!ocl_sh_rvalid || ocl_sh_rdata !== data) bad++;
    end
    chk("rdata_hold_changes", bad, 0);
    sh_ocl_rready = 1'b1;
    @(negedge clk_main_a0);
    sh_ocl_rready = 1'b0;
    chk("rvalid_after_rready", {31'h0, ocl_sh_rvalid}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   hs, bad, base;

    vecs[0] = '{1'b1, 32'h0000_1234, 32'hAABB_CCDD, 4'hF, 0, 5, 0, 16'h1234};
    vecs[1] = '{1'b1, 32'hFFFF_8000, 32'h0000_0001, 4'h0, 3, 0, 0, 16'h8000};
    vecs[2] = '{1'b1, 32'h0002_00FC, 32'h0102_0304, 4'h5, 0, 0, 0, 16'h00FC};
    vecs[3] = '{1'b0, 32'h0001_0040, 32'h1234_5678, 4'h0, 0, 0, 3, 16'h0040};
    vecs[4] = '{1'b0, 32'hABCD_FFFC, 32'hCAFE_F00D, 4'h0, 0, 0, 0, 16'hFFFC};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 2, 1, 0, 16'h0000};

    rst_main = 1'b1;
    sh_ocl_awvalid = 1'b0; sh_ocl_awaddr = '0;
    sh_ocl_wvalid = 1'b0;  sh_ocl_wdata = '0; sh_ocl_wstrb = '0;
    sh_ocl_bready = 1'b0;  sh_ocl_arvalid = 1'b0; sh_ocl_araddr = '0;
    sh_ocl_rready = 1'b0;  req_ready = 1'b1;
    repeat (3) @(negedge clk_main_a0);

    chk("reset_valid_ready", {25'h0, ocl_sh_awready, ocl_sh_wready, ocl_sh_arready, ocl_sh_bvalid,
                              ocl_sh_rvalid, req_valid, rsp_ready}, 32'h0);
    chk("reset_resp", {28'h0, ocl_sh_bresp, ocl_sh_rresp}, 32'h0);
    chk("reset_rdata", ocl_sh_rdata, 32'h0);
    chk("reset_req_fields", {req_wdata[14:0], req_write, req_addr} | {28'h0, req_wstrb}, 32'h0);
`ifdef OCL_TIMEOUT_EN
    chk("reset_timeout_seen", {31'h0, timeout_seen}, 32'h0);
`endif
    rst_main = 1'b0;
    @(negedge clk_main_a0);
    chk("awready_after_reset", {31'h0, ocl_sh_awready}, 32'h1);

    for (int i = 0; i < 6; i++) begin
      $display("txn %0d: %s addr=%h data=%h", i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].data);
      if (vecs[i].wr) begin
        exp_q.push_back(mk_wr(vecs[i].exp_addr, vecs[i].data, vecs[i].strb));
        send_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, hs);
        take_b(0, hs + 2);
      end else begin
        exp_q.push_back(mk_rd(vecs[i].exp_addr, vecs[i].data, vecs[i].rsp_dly, 1'b0));
        send_ar(vecs[i].addr);
        take_r(vecs[i].data, 2'b00, 2);
      end
    end
    chk("table_req_count", req_count, 6);

    // Round robin with a read last: the write waiting alongside a read goes first.
    $display("txn rr1: read 0x0100 busy, then write 0x0110 and read 0x0120 both pending");
    exp_q.push_back(mk_rd(16'h0100, 32'h1111_0000, 1, 1'b0));
    exp_q.push_back(mk_wr(16'h0110, 32'h2222_0000, 4'hF));
    exp_q.push_back(mk_rd(16'h0120, 32'h3333_0000, 0, 1'b0));
    fork
      begin
        send_ar(32'h0000_0100);
        take_r(32'h1111_0000, 2'b00, 8);
      end
      begin
        repeat (3) @(negedge clk_main_a0);
        fork
          begin
            send_write(32'h0000_0110, 32'h2222_0000, 4'hF, 0, 0, hs);
            take_b(0, -1);
          end
          send_ar(32'h0000_0120);
        join
      end
    join
    take_r(32'h3333_0000, 2'b00, 0);

    // Round robin with a write last: the pending read goes first.
    $display("txn rr2: write 0x0200 busy, then write 0x0210 and read 0x0220 both pending");
    exp_q.push_back(mk_wr(16'h0200, 32'h4444_0000, 4'h1));
    exp_q.push_back(mk_rd(16'h0220, 32'h5555_0000, 1, 1'b0));
    exp_q.push_back(mk_wr(16'h0210, 32'h6666_0000, 4'h2));
    send_write(32'h0000_0200, 32'h4444_0000, 4'h1, 0, 0, hs);
    fork
      take_b(8, -1);
      begin
        repeat (2) @(negedge clk_main_a0);
        fork
          send_write(32'h0000_0210, 32'h6666_0000, 4'h2, 0, 0, hs);
          send_ar(32'h0000_0220);
        join
      end
    join
    take_r(32'h5555_0000, 2'b00, 0);
    take_b(0, -1);

    // Portal back-pressure: request fields and bvalid must hold steady.
    $display("txn stall: write 0x0A0A with req_ready low 10 cycles, bready low 5");
    exp_q.push_back(mk_wr(16'h0A0A, 32'h0BAD_F00D, 4'h3));
    req_ready = 1'b0;
    send_write(32'h0000_0A0A, 32'h0BAD_F00D, 4'h3, 0, 0, hs);
    bad = 0;
    repeat (10) begin
      @(negedge clk_main_a0);
      if (!(req_valid && req_write && req_addr == 16'h0A0A && req_wdata == 32'h0BAD_F00D &&
            req_wstrb == 4'h3 && !ocl_sh_bvalid)) bad++;
    end
    chk("req_stall_unstable_cycles", bad, 0);
    base = req_count;
    req_ready = 1'b1;
    take_b(5, -1);
    bad = 0;
    repeat (4) begin
      @(negedge clk_main_a0);
      if (ocl_sh_bvalid || req_valid) bad++;
    end
    chk("stall_extra_activity", bad, 0);
    chk("stall_req_count", req_count - base, 1);

`ifdef OCL_TIMEOUT_EN
    $display("txn timeout: read 0x0300 with no portal response");
    exp_q.push_back(mk_rd(16'h0300, 32'h0, 0, 1'b1));
    send_ar(32'h0000_0300);
    take_r(32'hDEAD_BEEF, 2'b10, 1);
    chk("timeout_seen", {31'h0, timeout_seen}, 32'h1);
    stray_req = 1'b1;
    repeat (4) @(negedge clk_main_a0);
    chk("stray_rsp_no_rvalid", {31'h0, ocl_sh_rvalid}, 32'h0);
    $display("txn timeout_follow: read 0x0304");
    exp_q.push_back(mk_rd(16'h0304, 32'h7777_8888, 2, 1'b0));
    send_ar(32'h0000_0304);
    take_r(32'h7777_8888, 2'b00, 0);
`endif

    // Reset while a read waits on the portal, with a stale AW sitting in its hold.
    $display("txn reset: read 0x0400 stuck in RD_WAIT, AW 0x0BAD held, reset pulsed");
    exp_q.push_back(mk_rd(16'h0400, 32'h0, 0, 1'b1));
    send_ar(32'h0000_0400);
    repeat (2) @(negedge clk_main_a0);
    send_aw(32'h0000_0BAD, 0, hs);
    rst_main = 1'b1;
    @(negedge clk_main_a0);
    chk("valids_after_reset_pulse", {25'h0, ocl_sh_awready, ocl_sh_wready, ocl_sh_arready,
                                     ocl_sh_bvalid, ocl_sh_rvalid, req_valid, rsp_ready}, 32'h0);
    rst_main = 1'b0;
    @(negedge clk_main_a0);
    $display("txn post_reset: write 0x0C0C");
    exp_q.push_back(mk_wr(16'h0C0C, 32'h9ABC_DEF0, 4'hF));
    send_write(32'h0000_0C0C, 32'h9ABC_DEF0, 4'hF, 0, 0, hs);
    take_b(0, hs + 2);

    repeat (3) @(negedge clk_main_a0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ocl_portal_bridge.md
Name: ocl_portal_bridge

Overview:
AXI-Lite slave front-end for the shell OCL (BAR) interface; sits between the shell sh_ocl_*/ocl_sh_* signals and the portal MMIO request/response fabric inside mkAwsF1Top. Holds AW/W until both are present, serialises reads and writes into one request stream and returns B/R responses. One transaction in flight.

Parameters:
ADDR_W, 16, portal address bits forwarded (low bits of sh_ocl_awaddr/araddr)
TIMEOUT_CYCLES, 4096, read-response timeout (used only with OCL_TIMEOUT_EN)

Ports:
clk_main_a0  in  1  sole clock
rst_main  in  1  synchronous reset, active-high
sh_ocl_awvalid/awaddr  in  1/32  write address
ocl_sh_awready  out  1
sh_ocl_wvalid/wdata/wstrb  in  1/32/4  write data
ocl_sh_wready  out  1
ocl_sh_bvalid/bresp  out  1/2  write response
sh_ocl_bready  in  1
sh_ocl_arvalid/araddr  in  1/32  read address
ocl_sh_arready  out  1
ocl_sh_rvalid/rdata/rresp  out  1/32/2  read data
sh_ocl_rready  in  1
req_valid  out  1  portal request valid
req_ready  in  1
req_write/req_addr/req_wdata/req_wstrb  out  1/ADDR_W/32/4
rsp_valid  in  1  portal read data valid
rsp_data  in  32
rsp_ready  out  1

Behaviour:
- Reset: all ready/valid outputs 0, bresp/rresp 0, rdata 0, req_* fields 0, FSM IDLE, rr_last_write 0, aw_held/w_held 0.
- AW and W captured independently into holding registers; awready=!aw_held, wready=!w_held (state-independent). Either order, same cycle, any gap.
- FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- arready=1 only in IDLE when read is selected; address latched on that handshake.
- IDLE: write pending = aw_held&&w_held; read pending = sh_ocl_arvalid. Both pending -> round-robin: pick opposite of rr_last_write. Write -> WR_REQ, clear holds, update rr_last_write=1. Read -> RD_REQ, rr_last_write=0.
- WR_REQ: req_valid=1, req_write=1, fields from holds; on req_ready -> WR_RESP. Holds may reload during WR_REQ (next write).
- WR_RESP: bvalid=1, bresp=OKAY(00); on bready -> IDLE. Earliest bvalid: 2 cycles after both AW and W held (IDLE cycle + accepted WR_REQ cycle).
- RD_REQ: req_valid=1, req_write=0, req_wdata/wstrb 0; on req_ready -> RD_WAIT.
- RD_WAIT: rsp_ready=1; on rsp_valid capture rsp_data -> RD_RESP. rsp_valid outside RD_WAIT is ignored (rsp_ready=0).
- RD_RESP: rvalid=1, rresp=OKAY; rdata stable until rready -> IDLE.
- All outputs registered; req_* held stable while req_valid && !req_ready.
- Address: req_addr = awaddr/araddr[ADDR_W-1:0]; upper bits dropped, no decode error.
- wstrb=0 forwarded unchanged (portal treats as no-op).
- Reset mid-transaction: drops in-flight op, holds cleared, no response issued.

Optional Feature:
OCL_TIMEOUT_EN: 32-bit-safe counter runs in RD_WAIT; reaching TIMEOUT_CYCLES without rsp_valid -> RD_RESP with rresp=SLVERR(10), rdata=32'hDEAD_BEEF; a later stray rsp_valid is discarded. A sticky timeout_seen output (1 bit, reset 0) is added. Without macro: RD_WAIT waits indefinitely, no extra port.

Decomposition:
- Package ocl_portal_pkg: state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10), TIMEOUT_RDATA constant.
- No sub-module; single file. Hold registers inline.

Test Plan:
- AW at cycle 0, W at cycle 5, req_ready=1 -> one req_write=1 with addr/data matched, bvalid 2 cycles after W, bresp=00.
- Read araddr=0x0001_0040 (ADDR_W=16), rsp_data=0x1234_5678 after 3 cycles -> req_addr=0x0040, rdata=0x1234_5678, rresp=00.
- Write and read pending same IDLE cycle, rr_last_write=0 -> write issued first, read next; repeat with write last -> read first.
- req_ready low 10 cycles in WR_REQ, bready low 5 cycles -> req fields and bvalid stable, exactly one request, one response.
- OCL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no rsp_valid -> rresp=10, rdata=0xDEADBEEF, timeout_seen=1; late rsp_valid ignored.
- rst_main pulsed in RD_WAIT -> all valids 0 next cycle; following write completes normally.
